uart_rx: RTL

Byte-wide 8N1 UART receiver, the receive-side counterpart of `uart_tx`, running directly on the board system clock. It synchronises the asynchronous serial line, validates the start bit, samples each bit at its centre using a per-bit clock counter, and presents the received byte through a valid/ack handshake. It also reports framing and overrun errors. It sits beside `uart_tx` in the board top, with `i_uart_rx` wired to the board pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the board-level uart_rx / uart_tx pair.
// Holds the receiver state encoding and the default line parameters.
package uart_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// Ports: i_clk, i_reset_n (async, active low), i_d (async in), o_q (synced out).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, valid/ack byte handoff.
// Ports: i_clk, i_reset_n, i_uart_rx (pin), o_data/o_data_valid/i_data_ack,
// sticky o_frame_err and o_overrun (both cleared by i_data_ack).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_uart_rx,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_data_valid,
  input  logic                   i_data_ack,
  output logic                   o_frame_err,
  output logic                   o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_rx_state_e state_q, state_d;

  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q,   shift_d;
  logic [UART_DATA_W-1:0] data_q,    data_d;
  logic                   valid_q,   valid_d;
  logic                   ferr_q,    ferr_d;
  logic                   ovr_q,     ovr_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_uart_rx),
    .o_q       (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;

    // Ack clears first; any set below in the same cycle overrides it.
    if (i_data_ack) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            // Line went back high before mid-bit: treat as noise.
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (!valid_q || i_data_ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            // Bad stop bit: hold off until the line idles so a long
            // break reports a single frame error.
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule
